// File: rtl/arith_pkg.sv
// Shared types and selector encodings for the arithmetic core.
package arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

    localparam logic [1:0]  SEL_QUOT       = 2'b00;
    localparam logic [1:0]  SEL_REM        = 2'b01;
    localparam int unsigned SEL_SIGNED_BIT = 1;

endpackage

// File: rtl/divider_seq_div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract the divisor.
module div_step #(
    parameter int unsigned bus = 4
) (
    input  logic [bus-1:0] rem_i,
    input  logic           q_msb_i,
    input  logic [bus-1:0] b_i,
    output logic [bus-1:0] rem_o,
    output logic           q_bit_o
);

    logic [bus:0] shifted;
    logic [bus:0] diff;

    // Shift is kept bus+1 wide so a partial remainder with its MSB set is not truncated.
    always_comb begin
        shifted = {rem_i, q_msb_i};
        diff    = shifted - {1'b0, b_i};
        q_bit_o = ~diff[bus];
        rem_o   = diff[bus] ? shifted[bus-1:0] : diff[bus-1:0];
    end

endmodule

// File: rtl/divider_seq.sv
// Iterative restoring divider, one quotient bit per cycle, start/busy/done handshake.
// Define DIVIDER_SEQ_SIGNED_EN to enable two's-complement division via selector[1].
module divider_seq
    import arith_pkg::*;
#(
    parameter int unsigned bus = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [bus-1:0] a,
    input  logic [bus-1:0] b,
    input  logic [1:0]     selector,
    output logic [bus-1:0] result,
    output logic           div_zero,
    output logic           busy,
    output logic           done
);

    localparam int unsigned CW = (bus > 1) ? $clog2(bus) : 1;

    div_state_t     state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [bus-1:0] q_q, q_d;
    logic [bus-1:0] rem_q, rem_d;
    logic [bus-1:0] b_q, b_d;
    logic           sel_rem_q, sel_rem_d;
    logic           neg_q_q, neg_q_d;
    logic           neg_r_q, neg_r_d;
    logic [bus-1:0] result_q, result_d;
    logic           dz_q, dz_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;

    logic [bus-1:0] a_abs, b_abs;
    logic           a_neg, b_neg;
    logic [bus-1:0] step_rem;
    logic           step_qbit;
    logic [bus-1:0] q_next;

    // Operand conditioning: magnitudes and signs captured at latch time.
`ifdef DIVIDER_SEQ_SIGNED_EN
    always_comb begin
        a_neg = selector[SEL_SIGNED_BIT] & a[bus-1];
        b_neg = selector[SEL_SIGNED_BIT] & b[bus-1];
        a_abs = a_neg ? (~a + bus'(1)) : a;
        b_abs = b_neg ? (~b + bus'(1)) : b;
    end
`else
    logic unused_signed_sel;
    assign unused_signed_sel = selector[SEL_SIGNED_BIT];
    always_comb begin
        a_neg = 1'b0;
        b_neg = 1'b0;
        a_abs = a;
        b_abs = b;
    end
`endif

    div_step #(.bus(bus)) u_step (
        .rem_i   (rem_q),
        .q_msb_i (q_q[bus-1]),
        .b_i     (b_q),
        .rem_o   (step_rem),
        .q_bit_o (step_qbit)
    );

    assign q_next = {q_q[bus-2:0], step_qbit};

    // Next-state and output logic.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        q_d       = q_q;
        rem_d     = rem_q;
        b_d       = b_q;
        sel_rem_d = sel_rem_q;
        neg_q_d   = neg_q_q;
        neg_r_d   = neg_r_q;
        result_d  = result_q;
        dz_d      = dz_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    q_d       = a_abs;
                    b_d       = b_abs;
                    rem_d     = '0;
                    cnt_d     = CW'(bus - 1);
                    sel_rem_d = ((selector & 2'b01) == SEL_REM);
                    neg_q_d   = a_neg ^ b_neg;
                    neg_r_d   = a_neg;
                    if (b == '0) begin
                        // Divide-by-zero bypasses the iterations entirely.
                        state_d  = DONE;
                        done_d   = 1'b1;
                        dz_d     = 1'b1;
                        result_d = selector[0] ? a : '1;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                q_d   = q_next;
                rem_d = step_rem;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    dz_d    = 1'b0;
                    if (sel_rem_q) begin
                        result_d = neg_r_q ? (~step_rem + bus'(1)) : step_rem;
                    end else begin
                        result_d = neg_q_q ? (~q_next + bus'(1)) : q_next;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == RUN);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            q_q       <= '0;
            rem_q     <= '0;
            b_q       <= '0;
            sel_rem_q <= 1'b0;
            neg_q_q   <= 1'b0;
            neg_r_q   <= 1'b0;
            result_q  <= '0;
            dz_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            q_q       <= q_d;
            rem_q     <= rem_d;
            b_q       <= b_d;
            sel_rem_q <= sel_rem_d;
            neg_q_q   <= neg_q_d;
            neg_r_q   <= neg_r_d;
            result_q  <= result_d;
            dz_q      <= dz_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign result   = result_q;
    assign div_zero = dz_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_divider_seq.sv
// Self-checking bench for divider_seq: directed table at bus=4, corner sequences, random at bus=8.
module tb_divider_seq;

    typedef struct packed {
        logic [7:0] res;
        logic       dz;
        logic [7:0] cyc;
    } exp_t;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [1:0] sel;
        logic [3:0] res;
        logic       dz;
        string      nm;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       start4, dz4, busy4, done4;
    logic [3:0] a4, b4, res4;
    logic [1:0] sel4;
    logic       start8, dz8, busy8, done8;
    logic [7:0] a8, b8, res8;
    logic [1:0] sel8;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_fail = 0;

    divider_seq #(.bus(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .selector(sel4),
        .result(res4), .div_zero(dz4), .busy(busy4), .done(done4)
    );

    divider_seq #(.bus(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .selector(sel8),
        .result(res8), .div_zero(dz8), .busy(busy8), .done(done8)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Independent reference for the 8-bit instance.
    function automatic exp_t model8(input logic [7:0] a, input logic [7:0] b, input logic [1:0] sel);
        exp_t e;
        int   ia, ib;
        logic sgn;
`ifdef DIVIDER_SEQ_SIGNED_EN
        sgn = sel[1];
`else
        sgn = 1'b0;
`endif
        e.cyc = (b == 8'd0) ? 8'd1 : 8'd9;
        e.dz  = (b == 8'd0);
        if (b == 8'd0) begin
            e.res = sel[0] ? a : 8'hFF;
        end else if (sgn) begin
            ia = $signed(a);
            ib = $signed(b);
            e.res = sel[0] ? 8'(ia % ib) : 8'(ia / ib);
        end else begin
            e.res = sel[0] ? (a % b) : (a / b);
        end
        return e;
    endfunction

    task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic [1:0] sel,
                        input logic [3:0] er, input logic edz, input string nm);
        exp_t e;
        int   cyc, nb;
        logic [3:0] got;
        e.res = {4'h0, er};
        e.dz  = edz;
        e.cyc = (b == 4'd0) ? 8'd1 : 8'd5;
        @(negedge clk);
        a4 = a; b4 = b; sel4 = sel; start4 = 1'b1;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        start4 = 1'b0; a4 = ~a; b4 = b + 4'd1; sel4 = ~sel;
        cyc = 1; nb = 0;
        while (done4 !== 1'b1 && cyc < 30) begin
            nb += int'(busy4);
            @(negedge clk);
            cyc++;
        end
        e = sb.pop_front();
        got = res4;
        chk({nm, " latency"}, 32'(cyc), 32'(e.cyc));
        chk({nm, " result"}, 32'(res4), 32'(e.res));
        chk({nm, " div_zero"}, 32'(dz4), 32'(e.dz));
        chk({nm, " busy cycles"}, 32'(nb), 32'(e.cyc) - 32'd1);
        @(negedge clk);
        chk({nm, " done pulse"}, 32'(done4), 32'd0);
        chk({nm, " hold"}, 32'(res4), 32'(got));
    endtask

    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic [1:0] sel);
        exp_t e;
        int   cyc;
        @(negedge clk);
        a8 = a; b8 = b; sel8 = sel; start8 = 1'b1;
        sb.push_back(model8(a, b, sel));
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
        cyc = 1;
        while (done8 !== 1'b1 && cyc < 30) begin
            @(negedge clk);
            cyc++;
        end
        e = sb.pop_front();
        chk($sformatf("rnd %0h/%0h sel%0d latency", a, b, sel), 32'(cyc), 32'(e.cyc));
        chk($sformatf("rnd %0h/%0h sel%0d result", a, b, sel), 32'(res8), 32'(e.res));
        chk($sformatf("rnd %0h/%0h sel%0d div_zero", a, b, sel), 32'(dz8), 32'(e.dz));
        @(negedge clk);
    endtask

    vec_t vecs[$];
    int   dcyc[$];
    logic [3:0] dres[$];
    int   busy_rise;
    logic prev_busy;
    int   dcount;
    logic [7:0] ra, rb;

    initial begin
        rst = 1'b1;
        start4 = 1'b0; a4 = '0; b4 = '0; sel4 = '0;
        start8 = 1'b0; a8 = '0; b8 = '0; sel8 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset result", 32'(res4), 32'd0);
        chk("reset div_zero", 32'(dz4), 32'd0);
        chk("reset busy", 32'(busy4), 32'd0);
        chk("reset done", 32'(done4), 32'd0);
        chk("reset result8", 32'(res8), 32'd0);
        rst = 1'b0;

        vecs.push_back('{4'd13, 4'd3, 2'b00, 4'd4,  1'b0, "13/3 q"});
        vecs.push_back('{4'd13, 4'd3, 2'b01, 4'd1,  1'b0, "13/3 r"});
        vecs.push_back('{4'd9,  4'd0, 2'b00, 4'hF,  1'b1, "9/0 q"});
        vecs.push_back('{4'd9,  4'd0, 2'b01, 4'd9,  1'b1, "9/0 r"});
        vecs.push_back('{4'd2,  4'd7, 2'b00, 4'd0,  1'b0, "2/7 q"});
        vecs.push_back('{4'd2,  4'd7, 2'b01, 4'd2,  1'b0, "2/7 r"});
        vecs.push_back('{4'd15, 4'd1, 2'b00, 4'd15, 1'b0, "15/1 q"});
        vecs.push_back('{4'd15, 4'd1, 2'b01, 4'd0,  1'b0, "15/1 r"});
        vecs.push_back('{4'd15, 4'd9, 2'b00, 4'd1,  1'b0, "15/9 q"});
        vecs.push_back('{4'd15, 4'd9, 2'b01, 4'd6,  1'b0, "15/9 r"});
        vecs.push_back('{4'd13, 4'd3, 2'b10, 4'd4,  1'b0, "13/3 sel10"});
        vecs.push_back('{4'd7,  4'd2, 2'b11, 4'd1,  1'b0, "7/2 sel11"});
`ifdef DIVIDER_SEQ_SIGNED_EN
        vecs.push_back('{4'h9,  4'd2, 2'b10, 4'hD,  1'b0, "-7/2 sq"});
        vecs.push_back('{4'h9,  4'd2, 2'b11, 4'hF,  1'b0, "-7/2 sr"});
        vecs.push_back('{4'h8,  4'hF, 2'b10, 4'h8,  1'b0, "-8/-1 sq"});
        vecs.push_back('{4'h8,  4'hF, 2'b11, 4'h0,  1'b0, "-8/-1 sr"});
        vecs.push_back('{4'h9,  4'h0, 2'b11, 4'h9,  1'b1, "-7/0 sr"});
`else
        vecs.push_back('{4'h9,  4'd2, 2'b10, 4'd4,  1'b0, "9/2 sel10"});
        vecs.push_back('{4'h8,  4'hF, 2'b11, 4'h8,  1'b0, "8/15 sel11"});
`endif
        foreach (vecs[i]) run4(vecs[i].a, vecs[i].b, vecs[i].sel, vecs[i].res, vecs[i].dz, vecs[i].nm);

        // start held high across two operations; operands change right after the first latch
        @(negedge clk);
        a4 = 4'd13; b4 = 4'd3; sel4 = 2'b00; start4 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a4 = 4'd2; b4 = 4'd7;
        prev_busy = busy4;
        busy_rise = 0;
        for (int c = 1; c <= 12; c++) begin
            if (done4 === 1'b1) begin
                dcyc.push_back(c);
                dres.push_back(res4);
            end
            if (busy4 === 1'b1 && prev_busy !== 1'b1 && busy_rise == 0) busy_rise = c;
            prev_busy = busy4;
            if (c == 12) start4 = 1'b0;
            @(negedge clk);
        end
        chk("held start done count", 32'(dcyc.size()), 32'd2);
        if (dcyc.size() == 2) begin
            chk("held start first done", 32'(dcyc[0]), 32'd5);
            chk("held start first result", 32'(dres[0]), 32'd4);
            chk("held start second done", 32'(dcyc[1]), 32'd11);
            chk("held start second result", 32'(dres[1]), 32'd0);
        end
        chk("held start relatch cycle", 32'(busy_rise), 32'd7);
        repeat (2) @(negedge clk);

        // reset asserted for two cycles in the middle of a division
        @(negedge clk);
        a4 = 4'd13; b4 = 4'd3; sel4 = 2'b00; start4 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start4 = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        dcount = 0;
        @(negedge clk);
        chk("mid-run rst busy", 32'(busy4), 32'd0);
        chk("mid-run rst result", 32'(res4), 32'd0);
        chk("mid-run rst done", 32'(done4), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            dcount += int'(done4);
            @(negedge clk);
        end
        chk("mid-run rst no done", 32'(dcount), 32'd0);
        run4(4'd13, 4'd3, 2'b00, 4'd4, 1'b0, "post-rst 13/3");

        for (int n = 0; n < 1000; n++) begin
            ra = 8'($urandom);
            rb = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom);
            if (n == 0) begin ra = 8'h80; rb = 8'hFF; end
            if (n == 1) begin ra = 8'hFF; rb = 8'h81; end
            run8(ra, rb, 2'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
